// File: rtl/cpld_pkg.sv
// Shared constants and FSM encoding for the SRAM address loader.
package cpld_pkg;

  localparam int ADDR_W_DEFAULT = 24;
  localparam int BCNT_W_DEFAULT = $clog2(ADDR_W_DEFAULT + 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SNES  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus a history flop.
// Provides the synchronised level and single-cycle rise/fall strobes.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
      s3_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = ~s3_q & s2_q;
  assign fall_o  = s3_q & ~s2_q;

endmodule

// File: rtl/sram_addr_loader.sv
// Serial address loader with auto-increment counter and SNES/AVR SRAM address mux.
// Optional feature macro: SRAM_ADDR_WRAP_DETECT_EN (saturating counter + sticky addr_wrap).
module sram_addr_loader
  import cpld_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              avr_clk_i,
  input  logic              avr_reset_n_i,
  input  logic              avr_si_i,
  input  logic              avr_sreg_en_n_i,
  input  logic              avr_counter_n_i,
  input  logic              avr_snes_mode_i,
  input  logic [ADDR_W-1:0] snes_addr_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              load_ok_o,
  output logic              load_err_o,
  output logic              addr_wrap_o
);

  localparam int BCNT_W = $clog2(ADDR_W + 2);
  localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(ADDR_W);
  localparam logic [BCNT_W-1:0] BCNT_MAX  = BCNT_W'(ADDR_W + 1);

  logic si_lvl, sreg_lvl, sreg_rise, strobe_fall, snes_lvl;

  sync_edge #(.RESET_VAL(1'b0)) u_sync_si (
    .clk_i(avr_clk_i), .rst_ni(avr_reset_n_i), .d_i(avr_si_i),
    .level_o(si_lvl), .rise_o(), .fall_o()
  );

  sync_edge #(.RESET_VAL(1'b1)) u_sync_sreg (
    .clk_i(avr_clk_i), .rst_ni(avr_reset_n_i), .d_i(avr_sreg_en_n_i),
    .level_o(sreg_lvl), .rise_o(sreg_rise), .fall_o()
  );

  sync_edge #(.RESET_VAL(1'b1)) u_sync_strobe (
    .clk_i(avr_clk_i), .rst_ni(avr_reset_n_i), .d_i(avr_counter_n_i),
    .level_o(), .rise_o(), .fall_o(strobe_fall)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_sync_snes (
    .clk_i(avr_clk_i), .rst_ni(avr_reset_n_i), .d_i(avr_snes_mode_i),
    .level_o(snes_lvl), .rise_o(), .fall_o()
  );

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   shreg_q, shreg_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [ADDR_W-1:0]   sram_q, sram_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
`ifdef SRAM_ADDR_WRAP_DETECT_EN
  logic                wrap_q, wrap_d;
`endif

  always_ff @(posedge avr_clk_i or negedge avr_reset_n_i) begin
    if (!avr_reset_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      bcnt_q  <= '0;
      sram_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef SRAM_ADDR_WRAP_DETECT_EN
      wrap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      sram_q  <= sram_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
`ifdef SRAM_ADDR_WRAP_DETECT_EN
      wrap_q  <= wrap_d;
`endif
    end
  end

  // SNES mode outranks every other event; a load outranks a coincident strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
`ifdef SRAM_ADDR_WRAP_DETECT_EN
    wrap_d  = wrap_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (snes_lvl) begin
          state_d = ST_SNES;
        end else if (!sreg_lvl) begin
          state_d = ST_SHIFT;
          bcnt_d  = '0;
        end else if (strobe_fall) begin
`ifdef SRAM_ADDR_WRAP_DETECT_EN
          if (&cnt_q) begin
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
`else
          cnt_d = cnt_q + ADDR_W'(1);
`endif
        end
      end
      ST_SHIFT: begin
        if (snes_lvl) begin
          state_d = ST_SNES;
          bcnt_d  = '0;
        end else if (sreg_rise) begin
          state_d = ST_IDLE;
          if (bcnt_q == BCNT_FULL) begin
            cnt_d = shreg_q;
            ok_d  = 1'b1;
`ifdef SRAM_ADDR_WRAP_DETECT_EN
            wrap_d = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else if (strobe_fall) begin
          shreg_d = {shreg_q[ADDR_W-2:0], si_lvl};
          if (bcnt_q != BCNT_MAX) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end
      ST_SNES: begin
        if (!snes_lvl) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sram_d = cnt_q;
    if (state_q == ST_SNES) begin
      sram_d = snes_addr_i;
    end
  end

  assign sram_addr_o = sram_q;
  assign load_ok_o   = ok_q;
  assign load_err_o  = err_q;
`ifdef SRAM_ADDR_WRAP_DETECT_EN
  assign addr_wrap_o = wrap_q;
`else
  assign addr_wrap_o = 1'b0;
`endif

endmodule

// File: tb/tb_sram_addr_loader.sv
// Randomised self-checking bench for sram_addr_loader against a transaction-level model.
// Expectations follow SRAM_ADDR_WRAP_DETECT_EN the same way the design build does.
module tb_sram_addr_loader;
  import cpld_pkg::*;

  localparam int AW = 24;
  localparam int OP_LOAD = 0;
  localparam int OP_INC  = 1;
  localparam int OP_SNES = 2;

  logic          clk = 1'b0;
  logic          resetN;
  logic          si, sregEnN, counterN, snesMode;
  logic [AW-1:0] snesAddr;
  logic [AW-1:0] sramAddr;
  logic          loadOk, loadErr, addrWrap;

  int total = 0;
  int bad   = 0;
  int okSeen  = 0;
  int errSeen = 0;

  // Transaction-level model: the value the address counter should hold.
  logic [AW-1:0] modelCnt;
  logic          modelWrap;

  always #5 clk = ~clk;

  sram_addr_loader #(.ADDR_W(AW)) dut (
    .avr_clk_i      (clk),
    .avr_reset_n_i  (resetN),
    .avr_si_i       (si),
    .avr_sreg_en_n_i(sregEnN),
    .avr_counter_n_i(counterN),
    .avr_snes_mode_i(snesMode),
    .snes_addr_i    (snesAddr),
    .sram_addr_o    (sramAddr),
    .load_ok_o      (loadOk),
    .load_err_o     (loadErr),
    .addr_wrap_o    (addrWrap)
  );

  // Count pulse cycles so each transaction can check for exactly one pulse.
  always @(negedge clk) begin
    if (loadOk)  okSeen++;
    if (loadErr) errSeen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    counterN = 1'b0;
    waitCycles(4);
    counterN = 1'b1;
    waitCycles(4);
  endtask

  task automatic shiftBits(input logic [31:0] value, input int nbits);
    sregEnN = 1'b0;
    waitCycles(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      si = value[i];
      waitCycles(4);
      strobe();
    end
  endtask

  task automatic modelIncrement();
`ifdef SRAM_ADDR_WRAP_DETECT_EN
    if (modelCnt == {AW{1'b1}}) modelWrap = 1'b1;
    else modelCnt = modelCnt + 1'b1;
`else
    modelCnt = modelCnt + 1'b1;
`endif
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_addr"}, 32'(sramAddr), 32'(modelCnt));
    checkOutput({tag, "_wrap"}, 32'(addrWrap), 32'(modelWrap));
  endtask

  // op LOAD: shift n bits of value; op INC: n strobes; op SNES: session showing value, n strobes.
  task automatic applyStimulus(input int op, input logic [31:0] value, input int n);
    logic [AW-1:0] other;
    case (op)
      OP_LOAD: begin
        shiftBits(value, n);
        okSeen  = 0;
        errSeen = 0;
        sregEnN = 1'b1;
        waitCycles(6);
        if (n == AW) begin
          modelCnt  = value[AW-1:0];
          modelWrap = 1'b0;
        end
        checkOutput("load_ok_pulses", 32'(okSeen), (n == AW) ? 32'd1 : 32'd0);
        checkOutput("load_err_pulses", 32'(errSeen), (n == AW) ? 32'd0 : 32'd1);
        checkState("after_load");
      end
      OP_INC: begin
        for (int i = 0; i < n; i++) begin
          strobe();
          modelIncrement();
        end
        waitCycles(2);
        checkState("after_inc");
      end
      default: begin
        snesAddr = value[AW-1:0];
        snesMode = 1'b1;
        waitCycles(5);
        checkOutput("snes_addr", 32'(sramAddr), 32'(value[AW-1:0]));
        for (int i = 0; i < n; i++) strobe();
        other = AW'($urandom);
        snesAddr = other;
        waitCycles(2);
        checkOutput("snes_track", 32'(sramAddr), 32'(other));
        snesMode = 1'b0;
        waitCycles(6);
        checkState("after_snes");
      end
    endcase
  endtask

  initial begin
    logic [AW-1:0] oldAddr;
    int op;
    int len;

    resetN   = 1'b0;
    si       = 1'b0;
    sregEnN  = 1'b1;
    counterN = 1'b1;
    snesMode = 1'b0;
    snesAddr = '0;
    modelCnt  = '0;
    modelWrap = 1'b0;
    waitCycles(3);
    resetN = 1'b1;
    waitCycles(6);
    checkOutput("reset_addr", 32'(sramAddr), 32'd0);
    checkOutput("reset_ok", 32'(loadOk), 32'd0);
    checkOutput("reset_err", 32'(loadErr), 32'd0);
    checkOutput("reset_wrap", 32'(addrWrap), 32'd0);
    checkOutput("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
    checkOutput("reset_pulses", 32'(okSeen + errSeen), 32'd0);

    // Cycle-exact load: sreg_en_n rises just before edge k.
    shiftBits(32'h0012ABCD, AW);
    oldAddr = modelCnt;
    okSeen  = 0;
    errSeen = 0;
    @(posedge clk);
    #1;
    sregEnN = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("k2_load_ok", 32'(loadOk), 32'd1);
    checkOutput("k2_addr_old", 32'(sramAddr), 32'(oldAddr));
    @(negedge clk);
    checkOutput("k3_load_ok_gone", 32'(loadOk), 32'd0);
    checkOutput("k3_addr_new", 32'(sramAddr), 32'h0012ABCD);
    waitCycles(4);
    checkOutput("k_ok_pulses", 32'(okSeen), 32'd1);
    checkOutput("k_err_pulses", 32'(errSeen), 32'd0);
    modelCnt = 24'h12ABCD;

    applyStimulus(OP_LOAD, 32'h00555555, AW - 1);
    applyStimulus(OP_LOAD, 32'h01FFFFFF, AW + 1);
    applyStimulus(OP_LOAD, 32'h00FFFFFE, AW);
    applyStimulus(OP_INC, 32'd0, 3);
    applyStimulus(OP_LOAD, 32'h00000100, AW);
    applyStimulus(OP_SNES, 32'h007E0000, 2);

    // Reset in the middle of a shift discards the partial address.
    shiftBits(32'h000003A5, 10);
    okSeen  = 0;
    errSeen = 0;
    #3;
    resetN = 1'b0;
    #4;
    checkOutput("midreset_addr", 32'(sramAddr), 32'd0);
    @(negedge clk);
    resetN    = 1'b1;
    modelCnt  = '0;
    modelWrap = 1'b0;
    waitCycles(4);
    sregEnN = 1'b1;
    waitCycles(6);
    checkOutput("midreset_no_ok", 32'(okSeen), 32'd0);
    checkOutput("midreset_err", 32'(errSeen), 32'd1);
    checkState("midreset");

    for (int it = 0; it < 24; it++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0: applyStimulus(OP_LOAD, 32'($urandom) & 32'h00FFFFFF, AW);
        1: applyStimulus(OP_LOAD, 32'h00FFFFFD - 32'($urandom_range(0, 1)), AW);
        2: begin
          len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, AW - 1))
                                             : int'($urandom_range(AW + 1, AW + 3));
          applyStimulus(OP_LOAD, $urandom, len);
        end
        3: applyStimulus(OP_INC, 32'd0, int'($urandom_range(1, 4)));
        default: applyStimulus(OP_SNES, 32'($urandom) & 32'h00FFFFFF, int'($urandom_range(0, 2)));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
